// File: rtl/host_bus_master_pkg.sv
// host_bus_master_pkg: shared widths, bus command codes, FSM states and window decode
package host_bus_master_pkg;

  localparam int data_size = 32;
  localparam int padd_size = 24;
  localparam int cmd_size  = 3;

  localparam logic [cmd_size-1:0] CMD_NOP   = 3'b000;
  localparam logic [cmd_size-1:0] CMD_READ  = 3'b001;
  localparam logic [cmd_size-1:0] CMD_WRITE = 3'b010;

  localparam logic [padd_size-1:0] BASE_ADDR_DEF = 24'h080000;
  localparam logic [padd_size-1:0] WIN_SIZE_DEF  = 24'h000100;

  typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, CAPT, RESP} state_t;

  typedef struct packed {
    logic                 write;
    logic [padd_size-1:0] addr;
    logic [data_size-1:0] wdata;
  } req_t;

  // One extra bit keeps base+win-1 from wrapping at the top of the address space
  function automatic logic in_window(input logic [padd_size-1:0] addr,
                                     input logic [padd_size-1:0] base,
                                     input logic [padd_size-1:0] win);
    logic [padd_size:0] a;
    logic [padd_size:0] lo;
    logic [padd_size:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, win} - {{padd_size{1'b0}}, 1'b1};
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/host_bus_master_req_fifo.sv
// host_req_fifo: 2-deep request queue with full/empty flags
module host_req_fifo
  import host_bus_master_pkg::*;
(
  input  logic clk0,
  input  logic reset_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty
);

  req_t       mem [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign full     = cnt == 2'd2;
  assign empty    = cnt == 2'd0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rp];

  // pointers and occupancy
  always_ff @(posedge clk0 or negedge reset_n)
    if (!reset_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) wp <= !wp;
      if (do_pop) rp <= !rp;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end

  // storage is only read while occupancy marks it valid, so it needs no reset
  always_ff @(posedge clk0)
    if (do_push) mem[wp] <= push_data;

endmodule

// File: rtl/host_bus_master.sv
// host_bus_master: queued CPU requests issued as single-cycle peripheral bus commands
module host_bus_master
  import host_bus_master_pkg::*;
#(
  parameter int                   RD_LAT    = 1,
  parameter logic [padd_size-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [padd_size-1:0] WIN_SIZE  = WIN_SIZE_DEF
) (
  input  logic                 clk0,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [padd_size-1:0] req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [data_size-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [cmd_size-1:0]  host_cmd,
  output logic [padd_size-1:0] host_addr,
  output logic [data_size-1:0] host_dataout,
  input  logic [data_size-1:0] host_datain
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  state_t     state;
  state_t     state_n;
  req_t       req_in;
  req_t       head;
  req_t       cur;
  logic       full;
  logic       empty;
  logic       pop;
  logic       head_ok;
  logic [1:0] wait_cnt;

  assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !full;
  assign head_ok   = in_window(head.addr, BASE_ADDR, WIN_SIZE);

  host_req_fifo u_fifo (
    .clk0      (clk0),
    .reset_n   (reset_n),
    .push      (req_valid && req_ready),
    .push_data (req_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // bus is driven only in the command cycle and is zero otherwise
  assign host_cmd     = state == CMD ? (cur.write ? CMD_WRITE : CMD_READ) : CMD_NOP;
  assign host_addr    = state == CMD ? cur.addr : '0;
  assign host_dataout = state == CMD && cur.write ? cur.wdata : '0;
  assign rsp_valid    = state == RESP;

  // state register
  always_ff @(posedge clk0 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  // next state and queue pop
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        pop     = !empty;
        state_n = empty ? IDLE : head_ok ? CMD : RESP;
      end
      CMD:     state_n = cur.write ? RESP : RD_LAT > 1 ? RD_WAIT : CAPT;
      RD_WAIT: state_n = wait_cnt == WAIT_LAST ? CAPT : RD_WAIT;
      CAPT:    state_n = RESP;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end

  // current request, read-latency counter and response register
  always_ff @(posedge clk0 or negedge reset_n)
    if (!reset_n) begin
      cur       <= '0;
      wait_cnt  <= 2'd0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) begin
        cur <= head;
        if (!head_ok) begin
          rsp_write <= head.write;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (state == CMD) begin
        wait_cnt <= 2'd0;
        if (cur.write) begin
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      end
      if (state == RD_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == CAPT) begin
        rsp_write <= 1'b0;
        rsp_rdata <= host_datain;
        rsp_err   <= 1'b0;
      end
    end

endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master: directed vectors and random traffic for read latencies 1 and 3
module tb_host_bus_master;
  import host_bus_master_pkg::*;

  localparam int BASE = 32'h080000;
  localparam int WIN  = 32'h000100;

  typedef struct packed {logic [2:0] c; logic [23:0] a; logic [31:0] d;} bus_t;
  typedef struct packed {logic w; logic e; logic [31:0] r;} rsp_t;
  typedef struct {
    logic w; logic [23:0] a; logic [31:0] d; logic [31:0] pre;
    bit has_cmd; logic [2:0] cmd; int rc1; int rc3;
    logic ew; logic [31:0] edat; logic eerr;
  } vec_t;

  logic        clk0 = 1'b0;
  logic        reset_n [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [23:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_write [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];
  logic [2:0]  host_cmd [2];
  logic [23:0] host_addr [2];
  logic [31:0] host_dataout [2];
  logic [31:0] host_datain [2];

  int passed = 0;
  int total  = 0;

  bus_t        eb [2][$];
  rsp_t        er [2][$];
  logic [31:0] mm [2][256];
  logic [31:0] pm [2][256];
  int          cd [2];
  logic [31:0] rdd [2];
  bit          pv [2];
  logic [33:0] prev [2];
  bit          rr_rand [2];
  bit          rr_val [2];
  vec_t        vt [8];

  always #5 clk0 = ~clk0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    host_bus_master #(.RD_LAT(g == 0 ? 1 : 3)) dut (
      .clk0         (clk0),
      .reset_n      (reset_n[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_write    (req_write[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_write    (rsp_write[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g]),
      .host_cmd     (host_cmd[g]),
      .host_addr    (host_addr[g]),
      .host_dataout (host_dataout[g]),
      .host_datain  (host_datain[g])
    );
  end

  function automatic int lat(input int k);
    return k == 0 ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (RD_LAT=%0d): got %h expected %h", nm, lat(k), act, exp);
  endtask

  // transaction-level model: every accepted request yields at most one bus command and one response
  task automatic model_push(input int k, input logic w, input logic [23:0] a, input logic [31:0] d);
    int ai;
    ai = int'(a);
    if (ai < BASE || ai >= BASE + WIN) er[k].push_back('{w: w, e: 1'b1, r: 32'h0});
    else if (w) begin
      eb[k].push_back('{c: CMD_WRITE, a: a, d: d});
      mm[k][ai - BASE] = d;
      er[k].push_back('{w: 1'b1, e: 1'b0, r: 32'h0});
    end else begin
      eb[k].push_back('{c: CMD_READ, a: a, d: 32'h0});
      er[k].push_back('{w: 1'b0, e: 1'b0, r: mm[k][ai - BASE]});
    end
  endtask

  // peripheral responder and bus/response scoreboard, sampled mid-cycle
  always @(negedge clk0) begin
    for (int k = 0; k < 2; k++) begin
      bus_t b;
      rsp_t r;
      if (!reset_n[k]) begin
        cd[k] = 0;
        pv[k] = 1'b0;
        host_datain[k] = $urandom;
        continue;
      end
      if (req_valid[k] && req_ready[k]) model_push(k, req_write[k], req_addr[k], req_wdata[k]);
      if (cd[k] == 1) begin
        cd[k] = 0;
        host_datain[k] = rdd[k];
      end else begin
        if (cd[k] != 0) cd[k]--;
        host_datain[k] = $urandom;
      end
      if (host_cmd[k] != CMD_NOP) begin
        chk("bus_cmd_expected", k, 64'(eb[k].size() != 0), 64'd1);
        if (eb[k].size() != 0) begin
          b = eb[k].pop_front();
          chk("bus_cmd", k, 64'(host_cmd[k]), 64'(b.c));
          chk("bus_addr", k, 64'(host_addr[k]), 64'(b.a));
          chk("bus_dataout", k, 64'(host_dataout[k]), 64'(b.d));
        end
        if (host_cmd[k] == CMD_WRITE) pm[k][host_addr[k][7:0]] = host_dataout[k];
        if (host_cmd[k] == CMD_READ) begin
          cd[k]  = lat(k);
          rdd[k] = pm[k][host_addr[k][7:0]];
        end
      end else chk("bus_idle_zero", k, {8'h0, host_addr[k], host_dataout[k]}, 64'h0);
      if (rsp_valid[k]) begin
        if (pv[k]) chk("rsp_stable", k, 64'({rsp_write[k], rsp_err[k], rsp_rdata[k]}), 64'(prev[k]));
        if (rsp_ready[k]) begin
          chk("rsp_expected", k, 64'(er[k].size() != 0), 64'd1);
          if (er[k].size() != 0) begin
            r = er[k].pop_front();
            chk("rsp_write", k, 64'(rsp_write[k]), 64'(r.w));
            chk("rsp_err", k, 64'(rsp_err[k]), 64'(r.e));
            chk("rsp_rdata", k, 64'(rsp_rdata[k]), 64'(r.r));
          end
          pv[k] = 1'b0;
        end else begin
          pv[k]   = 1'b1;
          prev[k] = {rsp_write[k], rsp_err[k], rsp_rdata[k]};
        end
      end else begin
        if (pv[k]) chk("rsp_held_until_ready", k, 64'(rsp_valid[k]), 64'd1);
        pv[k] = 1'b0;
      end
    end
  end

  // response-side backpressure
  always @(posedge clk0) begin
    #1;
    for (int k = 0; k < 2; k++) rsp_ready[k] = rr_rand[k] ? 1'($urandom_range(0, 1)) : rr_val[k];
  end

  // call at 1 time unit after a rising edge; returns at the same phase after acceptance
  task automatic send(input int k, input logic w, input logic [23:0] a, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk0);
      acc = req_ready[k];
      @(posedge clk0);
      #1;
    end
    if (!acc) chk("req_accept_timeout", k, 64'd0, 64'd1);
    req_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 400 && (eb[k].size() != 0 || er[k].size() != 0); i++) @(negedge clk0);
    chk("drain_outstanding", k, 64'(eb[k].size() + er[k].size()), 64'd0);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int ncmd, ccyc, rcyc;
    logic [2:0] c;
    logic [23:0] a;
    logic [31:0] d;
    logic rw, re;
    logic [31:0] rd;
    ncmd = 0; ccyc = -1; rcyc = -1;
    c = '0; a = '0; d = '0; rw = 1'b0; re = 1'b0; rd = '0;
    rr_rand[k] = 1'b0;
    rr_val[k]  = 1'b1;
    if (v.has_cmd && !v.w) begin
      pm[k][v.a[7:0]] = v.pre;
      mm[k][v.a[7:0]] = v.pre;
    end
    @(posedge clk0);
    #1;
    req_valid[k] = 1'b1;
    req_write[k] = v.w;
    req_addr[k]  = v.a;
    req_wdata[k] = v.d;
    @(posedge clk0);
    #1;
    req_valid[k] = 1'b0;
    for (int cy = 0; cy < 10; cy++) begin
      @(negedge clk0);
      if (host_cmd[k] != CMD_NOP) begin
        ncmd++;
        ccyc = cy;
        c = host_cmd[k]; a = host_addr[k]; d = host_dataout[k];
      end
      if (rsp_valid[k] && rcyc < 0) begin
        rcyc = cy;
        rw = rsp_write[k]; re = rsp_err[k]; rd = rsp_rdata[k];
      end
    end
    chk("vec_cmd_count", k, 64'(ncmd), 64'(v.has_cmd ? 1 : 0));
    if (v.has_cmd) begin
      chk("vec_cmd_cycle", k, 64'(ccyc), 64'd1);
      chk("vec_cmd", k, 64'(c), 64'(v.cmd));
      chk("vec_addr", k, 64'(a), 64'(v.a));
      chk("vec_dataout", k, 64'(d), 64'(v.w ? v.d : 32'h0));
    end
    chk("vec_rsp_cycle", k, 64'(rcyc), 64'(k == 0 ? v.rc1 : v.rc3));
    chk("vec_rsp_write", k, 64'(rw), 64'(v.ew));
    chk("vec_rsp_err", k, 64'(re), 64'(v.eerr));
    chk("vec_rsp_rdata", k, 64'(rd), 64'(v.edat));
  endtask

  task automatic back_to_back(input int k);
    rr_rand[k] = 1'b0;
    rr_val[k]  = 1'b0;
    @(posedge clk0);
    #1;
    send(k, 1'b1, 24'h080010, 32'h1111_0001);
    send(k, 1'b0, 24'h080010, 32'h0);
    send(k, 1'b1, 24'h080011, 32'h2222_0002);
    req_valid[k] = 1'b1;
    req_write[k] = 1'b0;
    req_addr[k]  = 24'h080011;
    req_wdata[k] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      chk("b2b_req_ready_low", k, 64'(req_ready[k]), 64'd0);
      chk("b2b_rsp_valid_held", k, 64'(rsp_valid[k]), 64'd1);
    end
    @(posedge clk0);
    #1;
    rr_val[k] = 1'b1;
    send(k, 1'b0, 24'h080011, 32'h0);
    drain(k);
  endtask

  task automatic random_traffic(input int k);
    logic [23:0] a;
    rr_rand[k] = 1'b1;
    @(posedge clk0);
    #1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: a = 24'(BASE - 1);
        1: a = 24'(BASE + WIN);
        2: a = 24'hFFFFFF;
        3: a = 24'($urandom);
        4: a = 24'(BASE);
        5: a = 24'(BASE + WIN - 1);
        default: a = 24'(BASE + int'($urandom_range(0, 255)));
      endcase
      send(k, 1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk0);
        #1;
      end
    end
    rr_rand[k] = 1'b0;
    rr_val[k]  = 1'b1;
    drain(k);
  endtask

  task automatic reset_mid_read(input int k);
    bit seen;
    int stale;
    seen = 1'b0;
    stale = 0;
    rr_val[k] = 1'b1;
    @(posedge clk0);
    #1;
    send(k, 1'b0, 24'h080005, 32'h0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk0);
      seen = host_cmd[k] == CMD_READ;
    end
    chk("rst_read_issued", k, 64'(seen), 64'd1);
    @(negedge clk0);
    #2;
    reset_n[k] = 1'b0;
    #1;
    chk("rst_async_cmd", k, 64'(host_cmd[k]), 64'(CMD_NOP));
    chk("rst_async_rsp_valid", k, 64'(rsp_valid[k]), 64'd0);
    chk("rst_async_req_ready", k, 64'(req_ready[k]), 64'd1);
    chk("rst_async_rdata", k, 64'(rsp_rdata[k]), 64'd0);
    eb[k].delete();
    er[k].delete();
    @(posedge clk0);
    #3;
    reset_n[k] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk0);
      if (rsp_valid[k] || host_cmd[k] != CMD_NOP) stale++;
    end
    chk("rst_no_stale_activity", k, 64'(stale), 64'd0);
  endtask

  initial begin
    vt[0] = '{1'b1, 24'h080022, 32'h0000_0064, 32'h0, 1'b1, CMD_WRITE, 2, 2, 1'b1, 32'h0, 1'b0};
    vt[1] = '{1'b0, 24'h080023, 32'h0, 32'hDEAD_BEEF, 1'b1, CMD_READ, 3, 5, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vt[2] = '{1'b0, 24'h090000, 32'h0, 32'h0, 1'b0, CMD_NOP, 1, 1, 1'b0, 32'h0, 1'b1};
    vt[3] = '{1'b1, 24'h07FFFF, 32'h55, 32'h0, 1'b0, CMD_NOP, 1, 1, 1'b1, 32'h0, 1'b1};
    vt[4] = '{1'b0, 24'h0800FF, 32'h0, 32'hA5A5_0001, 1'b1, CMD_READ, 3, 5, 1'b0, 32'hA5A5_0001, 1'b0};
    vt[5] = '{1'b0, 24'h080100, 32'h0, 32'h0, 1'b0, CMD_NOP, 1, 1, 1'b0, 32'h0, 1'b1};
    vt[6] = '{1'b1, 24'hFFFFFF, 32'h77, 32'h0, 1'b0, CMD_NOP, 1, 1, 1'b1, 32'h0, 1'b1};
    vt[7] = '{1'b1, 24'h080000, 32'hCAFE_0000, 32'h0, 1'b1, CMD_WRITE, 2, 2, 1'b1, 32'h0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        mm[k][i] = 32'(i) * 32'h9E37_79B1 + 32'h1234;
        pm[k][i] = mm[k][i];
      end
      reset_n[k]   = 1'b0;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      rr_rand[k]   = 1'b0;
      rr_val[k]    = 1'b1;
      cd[k]        = 0;
      pv[k]        = 1'b0;
    end
    repeat (3) @(posedge clk0);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", k, 64'(req_ready[k]), 64'd1);
      chk("reset_rsp_valid", k, 64'(rsp_valid[k]), 64'd0);
      chk("reset_rsp_write", k, 64'(rsp_write[k]), 64'd0);
      chk("reset_rsp_rdata", k, 64'(rsp_rdata[k]), 64'd0);
      chk("reset_rsp_err", k, 64'(rsp_err[k]), 64'd0);
      chk("reset_host_cmd", k, 64'(host_cmd[k]), 64'd0);
      chk("reset_host_addr", k, 64'(host_addr[k]), 64'd0);
      chk("reset_host_dataout", k, 64'(host_dataout[k]), 64'd0);
    end
    #2;
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) run_vec(k, vt[i]);
      back_to_back(k);
      random_traffic(k);
      reset_mid_read(k);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
